spatial_encoder_arbiter: RTL

Shares one non-pipelined spatial encoder between two sample producers. Requester 0 is the live classification stream and requester 1 is the training/update stream. The block arbitrates, latches the winning request and issues it to the encoder. It then buffers the returned hypervector and routes it back to the owning requester, holding one transaction in flight at a time. It sits between the sample framers and the spatial encoder, ahead of the temporal encoder/AM path.

---
 rtl/spatial_encoder_arbiter_pkg.sv | 26 ++
 rtl/spatial_encoder_arbiter_if.sv | 65 ++++++
 rtl/spatial_encoder_arbiter_grant.sv | 25 ++
 rtl/spatial_encoder_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/spatial_encoder_arbiter_pkg.sv
// Shared widths, FSM encoding and requester constants for spatial_encoder_arbiter.
// Optional build macro: SPATIAL_ARB_FIXED_PRIORITY_EN (see spatial_arb_grant).
package spatial_encoder_arbiter_pkg;

    localparam int DEF_CHANNEL_WIDTH  = 5;
    localparam int DEF_INPUT_CHANNELS = 4;
    localparam int DEF_MODE_WIDTH     = 2;
    localparam int DEF_LABEL_WIDTH    = 3;
    localparam int DEF_HV_DIMENSION   = 64;

    typedef enum logic [1:0] {
        SARB_IDLE    = 2'd0,
        SARB_ISSUE   = 2'd1,
        SARB_WAIT    = 2'd2,
        SARB_DELIVER = 2'd3
    } sarb_state_e;

    // Requester 0 is the live classification stream, requester 1 the training stream.
    localparam logic REQ_LIVE  = 1'b0;
    localparam logic REQ_TRAIN = 1'b1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spatial_encoder_arbiter_if.sv
// Request, encoder and response buses of spatial_encoder_arbiter.
// The slave modport is the arbiter's view; master is the producers/encoder side.
interface spatial_encoder_arbiter_if #(
    parameter int CHANNEL_WIDTH  = spatial_encoder_arbiter_pkg::DEF_CHANNEL_WIDTH,
    parameter int INPUT_CHANNELS = spatial_encoder_arbiter_pkg::DEF_INPUT_CHANNELS,
    parameter int MODE_WIDTH     = spatial_encoder_arbiter_pkg::DEF_MODE_WIDTH,
    parameter int LABEL_WIDTH    = spatial_encoder_arbiter_pkg::DEF_LABEL_WIDTH,
    parameter int HV_DIMENSION   = spatial_encoder_arbiter_pkg::DEF_HV_DIMENSION
);

    localparam int CH_BITS = CHANNEL_WIDTH * INPUT_CHANNELS;

    logic [1:0]              ReqValid_SI;
    logic [1:0]              ReqReady_SO;
    logic [MODE_WIDTH-1:0]   ReqMode0_SI;
    logic [MODE_WIDTH-1:0]   ReqMode1_SI;
    logic [LABEL_WIDTH-1:0]  ReqLabel0_DI;
    logic [LABEL_WIDTH-1:0]  ReqLabel1_DI;
    logic [CH_BITS-1:0]      ReqChannels0_DI;
    logic [CH_BITS-1:0]      ReqChannels1_DI;

    logic                    EncValid_SO;
    logic                    EncReady_SI;
    logic [MODE_WIDTH-1:0]   EncMode_SO;
    logic [LABEL_WIDTH-1:0]  EncLabel_DO;
    logic [CH_BITS-1:0]      EncChannels_DO;

    logic                    EncValid_SI;
    logic                    EncReady_SO;
    logic [MODE_WIDTH-1:0]   EncMode_SI;
    logic [LABEL_WIDTH-1:0]  EncLabel_DI;
    logic [HV_DIMENSION-1:0] EncHypervector_DI;

    logic [1:0]              RspValid_SO;
    logic [1:0]              RspReady_SI;
    logic [MODE_WIDTH-1:0]   RspMode_SO;
    logic [LABEL_WIDTH-1:0]  RspLabel_DO;
    logic [HV_DIMENSION-1:0] RspHypervector_DO;

    logic                    Owner_SO;
    logic                    Busy_SO;

    modport slave (
        input  ReqValid_SI, ReqMode0_SI, ReqMode1_SI, ReqLabel0_DI, ReqLabel1_DI,
               ReqChannels0_DI, ReqChannels1_DI,
               EncReady_SI, EncValid_SI, EncMode_SI, EncLabel_DI, EncHypervector_DI,
               RspReady_SI,
        output ReqReady_SO,
               EncValid_SO, EncMode_SO, EncLabel_DO, EncChannels_DO, EncReady_SO,
               RspValid_SO, RspMode_SO, RspLabel_DO, RspHypervector_DO,
               Owner_SO, Busy_SO
    );

    modport master (
        output ReqValid_SI, ReqMode0_SI, ReqMode1_SI, ReqLabel0_DI, ReqLabel1_DI,
               ReqChannels0_DI, ReqChannels1_DI,
               EncReady_SI, EncValid_SI, EncMode_SI, EncLabel_DI, EncHypervector_DI,
               RspReady_SI,
        input  ReqReady_SO,
               EncValid_SO, EncMode_SO, EncLabel_DO, EncChannels_DO, EncReady_SO,
               RspValid_SO, RspMode_SO, RspLabel_DO, RspHypervector_DO,
               Owner_SO, Busy_SO
    );

endinterface

// File: rtl/spatial_encoder_arbiter_grant.sv
// Combinational two-requester grant: round-robin on LastGrant by default,
// fixed priority for the live stream when SPATIAL_ARB_FIXED_PRIORITY_EN is defined.
module spatial_arb_grant
    import spatial_encoder_arbiter_pkg::*;
(
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

`ifdef SPATIAL_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    // The live stream wins every contested cycle.
    assign grant_idx_o = req_valid_i[REQ_LIVE] ? REQ_LIVE : REQ_TRAIN;
`else
    // A tie goes to whichever requester was not granted last.
    assign grant_idx_o = (&req_valid_i) ? ~last_grant_i : req_valid_i[REQ_TRAIN];
`endif

    assign grant_o = (|req_valid_i) ? req_onehot(grant_idx_o) : 2'b00;

endmodule

// File: rtl/spatial_encoder_arbiter.sv
// Shares one non-pipelined spatial encoder between the live and training sample streams,
// one transaction in flight. Build macro: SPATIAL_ARB_FIXED_PRIORITY_EN.
module spatial_encoder_arbiter
    import spatial_encoder_arbiter_pkg::*;
#(
    parameter int CHANNEL_WIDTH  = DEF_CHANNEL_WIDTH,
    parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
    parameter int MODE_WIDTH     = DEF_MODE_WIDTH,
    parameter int LABEL_WIDTH    = DEF_LABEL_WIDTH,
    parameter int HV_DIMENSION   = DEF_HV_DIMENSION
) (
    input  logic                       Clk_CI,
    input  logic                       Reset_RI,
    spatial_encoder_arbiter_if.slave   bus
);

    localparam int CH_BITS = CHANNEL_WIDTH * INPUT_CHANNELS;

    sarb_state_e             state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;

    logic [MODE_WIDTH-1:0]   iss_mode_q, iss_mode_d;
    logic [LABEL_WIDTH-1:0]  iss_label_q, iss_label_d;
    logic [CH_BITS-1:0]      iss_chan_q, iss_chan_d;

    logic [MODE_WIDTH-1:0]   rsp_mode_q, rsp_mode_d;
    logic [LABEL_WIDTH-1:0]  rsp_label_q, rsp_label_d;
    logic [HV_DIMENSION-1:0] rsp_hv_q, rsp_hv_d;

    logic [1:0]              grant;
    logic                    grant_idx;

    spatial_arb_grant u_grant (
        .req_valid_i  (bus.ReqValid_SI),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    // NOTE: issue and response registers are reset as well, because they drive
    // externally visible buses whose post-reset value is defined.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q      <= SARB_IDLE;
            owner_q      <= REQ_LIVE;
            last_grant_q <= REQ_TRAIN;
            iss_mode_q   <= '0;
            iss_label_q  <= '0;
            iss_chan_q   <= '0;
            rsp_mode_q   <= '0;
            rsp_label_q  <= '0;
            rsp_hv_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            iss_mode_q   <= iss_mode_d;
            iss_label_q  <= iss_label_d;
            iss_chan_q   <= iss_chan_d;
            rsp_mode_q   <= rsp_mode_d;
            rsp_label_q  <= rsp_label_d;
            rsp_hv_q     <= rsp_hv_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register, so no path through
        // the case leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        iss_mode_d   = iss_mode_q;
        iss_label_d  = iss_label_q;
        iss_chan_d   = iss_chan_q;
        rsp_mode_d   = rsp_mode_q;
        rsp_label_d  = rsp_label_q;
        rsp_hv_d     = rsp_hv_q;

        case (state_q)
            SARB_IDLE: begin
                if (|grant) begin
                    state_d      = SARB_ISSUE;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    iss_mode_d   = grant_idx ? bus.ReqMode1_SI     : bus.ReqMode0_SI;
                    iss_label_d  = grant_idx ? bus.ReqLabel1_DI    : bus.ReqLabel0_DI;
                    iss_chan_d   = grant_idx ? bus.ReqChannels1_DI : bus.ReqChannels0_DI;
                end
            end
            SARB_ISSUE: begin
                if (bus.EncReady_SI) state_d = SARB_WAIT;
            end
            SARB_WAIT: begin
                if (bus.EncValid_SI) begin
                    state_d     = SARB_DELIVER;
                    rsp_mode_d  = bus.EncMode_SI;
                    rsp_label_d = bus.EncLabel_DI;
                    rsp_hv_d    = bus.EncHypervector_DI;
                end
            end
            SARB_DELIVER: begin
                // Only the owner's ready completes the response.
                if (bus.RspReady_SI[owner_q]) state_d = SARB_IDLE;
            end
            default: state_d = SARB_IDLE;
        endcase
    end

    always_comb begin
        bus.ReqReady_SO = 2'b00;
        bus.EncValid_SO = 1'b0;
        bus.EncReady_SO = 1'b0;
        bus.RspValid_SO = 2'b00;

        case (state_q)
            SARB_IDLE:    bus.ReqReady_SO = grant;
            SARB_ISSUE:   bus.EncValid_SO = 1'b1;
            SARB_WAIT:    bus.EncReady_SO = 1'b1;
            SARB_DELIVER: bus.RspValid_SO = req_onehot(owner_q);
            default:      bus.ReqReady_SO = 2'b00;
        endcase
    end

    assign bus.EncMode_SO        = iss_mode_q;
    assign bus.EncLabel_DO       = iss_label_q;
    assign bus.EncChannels_DO    = iss_chan_q;
    assign bus.RspMode_SO        = rsp_mode_q;
    assign bus.RspLabel_DO       = rsp_label_q;
    assign bus.RspHypervector_DO = rsp_hv_q;
    assign bus.Owner_SO          = owner_q;
    assign bus.Busy_SO           = (state_q != SARB_IDLE);

endmodule
